// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding, lookahead group width and the
// registered flag bundle.
package alu_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_ADC = 2'b10;
   localparam logic [1:0] OP_SBB = 2'b11;

   localparam int GRP_W = 8;

   typedef struct packed {
      logic c;
      logic v;
      logic z;
      logic n;
   } alu_flags_t;

   // Subtracting forms feed the inverted B operand into the adder.
   function automatic logic op_inverts_b(input logic [1:0] op);
      return (op == OP_SUB) || (op == OP_SBB);
   endfunction

   function automatic logic op_cin(input logic [1:0] op, input logic cin);
      logic r;
      case (op)
         OP_ADD:  r = 1'b0;
         OP_SUB:  r = 1'b1;
         default: r = cin;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/cla_group_8.sv
// Combinational 8-bit carry-lookahead group: sum for a given carry-in plus the
// group generate/propagate used by the second-level lookahead.
module cla_group_8
   import alu_pkg::*;
(
   input  logic [GRP_W-1:0] a,
   input  logic [GRP_W-1:0] b,
   input  logic             cin,
   output logic [GRP_W-1:0] s,
   output logic             g,
   output logic             p
);

   logic [GRP_W-1:0] bit_g;
   logic [GRP_W-1:0] bit_p;
   logic             cy;

   always_comb begin
      bit_g = a & b;
      bit_p = a ^ b;
      s     = '0;
      cy    = cin;
      g     = 1'b0;
      for (int i = 0; i < GRP_W; i++) begin
         s[i] = bit_p[i] ^ cy;
         cy   = bit_g[i] | (bit_p[i] & cy);
         g    = bit_g[i] | (bit_p[i] & g);
      end
      p = &bit_p;
   end

endmodule

// File: rtl/addsub_cla_pipe.sv
// Two-stage pipelined add/subtract: stage 1 computes per-group conditional sums
// and G/P, stage 2 resolves group carries by lookahead and registers sum+flags.
module addsub_cla_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [1:0]       in_op,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_c,
   output logic             out_v,
   output logic             out_z,
   output logic             out_n
);

   localparam int NGRP = WIDTH / GRP_W;

   // Handshake: a beat moves on valid && ready. A stage advances when it is
   // empty or its downstream advances; in_ready depends on state/out_ready only.
   logic s1_valid;
   logic s2_adv;
   logic s1_adv;

   assign s2_adv   = !out_valid || out_ready;
   assign s1_adv   = !s1_valid || s2_adv;
   assign in_ready = s1_adv;

   logic [WIDTH-1:0]             b_eff;
   logic                         cin_eff;
   logic [NGRP-1:0][GRP_W-1:0]   sum0_d;
   logic [NGRP-1:0][GRP_W-1:0]   sum1_d;
   logic [NGRP-1:0]              g_d;
   logic [NGRP-1:0]              p_d;

   assign b_eff   = op_inverts_b(in_op) ? ~in_b : in_b;
   assign cin_eff = op_cin(in_op, in_cin);

   for (genvar k = 0; k < NGRP; k++) begin : g_grp
      cla_group_8 u_cin0 (
         .a   (in_a[k*GRP_W +: GRP_W]),
         .b   (b_eff[k*GRP_W +: GRP_W]),
         .cin (1'b0),
         .s   (sum0_d[k]),
         .g   (g_d[k]),
         .p   (p_d[k])
      );
      cla_group_8 u_cin1 (
         .a   (in_a[k*GRP_W +: GRP_W]),
         .b   (b_eff[k*GRP_W +: GRP_W]),
         .cin (1'b1),
         .s   (sum1_d[k]),
         .g   (),
         .p   ()
      );
   end

   logic [NGRP-1:0][GRP_W-1:0]   s1_sum0;
   logic [NGRP-1:0][GRP_W-1:0]   s1_sum1;
   logic [NGRP-1:0]              s1_g;
   logic [NGRP-1:0]              s1_p;
   logic                         s1_cin;
   logic                         s1_a_msb;
   logic                         s1_b_msb;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_sum0  <= '0;
         s1_sum1  <= '0;
         s1_g     <= '0;
         s1_p     <= '0;
         s1_cin   <= 1'b0;
         s1_a_msb <= 1'b0;
         s1_b_msb <= 1'b0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_sum0  <= sum0_d;
            s1_sum1  <= sum1_d;
            s1_g     <= g_d;
            s1_p     <= p_d;
            s1_cin   <= cin_eff;
            s1_a_msb <= in_a[WIDTH-1];
            s1_b_msb <= b_eff[WIDTH-1];
         end
      end
   end

   logic [NGRP:0]    c_grp;
   logic [WIDTH-1:0] sum_nx;
   alu_flags_t       flags_nx;
   alu_flags_t       flags_q;
   logic             prod;
   logic             cy;

   // Each group carry is an OR of independent product terms over the
   // registered G/P/cin, so no carry depends on a lower computed carry.
   always_comb begin
      c_grp    = '0;
      sum_nx   = '0;
      flags_nx = '0;
      prod     = 1'b0;
      cy       = 1'b0;
      c_grp[0] = s1_cin;
      for (int k = 0; k < NGRP; k++) begin
         prod = s1_cin;
         for (int m = 0; m <= k; m++) prod = prod & s1_p[m];
         cy = prod;
         for (int j = 0; j <= k; j++) begin
            prod = s1_g[j];
            for (int m = j + 1; m <= k; m++) prod = prod & s1_p[m];
            cy = cy | prod;
         end
         c_grp[k+1] = cy;
      end
      for (int k = 0; k < NGRP; k++) begin
         sum_nx[k*GRP_W +: GRP_W] = c_grp[k] ? s1_sum1[k] : s1_sum0[k];
      end
      flags_nx.c = c_grp[NGRP];
      flags_nx.v = (s1_a_msb == s1_b_msb) && (sum_nx[WIDTH-1] != s1_a_msb);
      flags_nx.z = ~|sum_nx;
      flags_nx.n = sum_nx[WIDTH-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_sum   <= '0;
         flags_q   <= '0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_sum <= sum_nx;
            flags_q <= flags_nx;
         end
      end
   end

   assign out_c = flags_q.c;
   assign out_v = flags_q.v;
   assign out_z = flags_q.z;
   assign out_n = flags_q.n;

endmodule

// File: tb/tb_addsub_cla_pipe.sv
// Self-checking bench for addsub_cla_pipe: directed vector table, backpressure,
// mid-stream reset and randomized traffic checked through an expected queue.
module tb_addsub_cla_pipe;
   import alu_pkg::*;

   localparam int W  = 32;
   localparam int EW = W + 4;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [1:0]   op;
      logic         cin;
      logic [W-1:0] sum;
      logic         c, v, z, n;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_ready;
   logic [W-1:0] in_a, in_b;
   logic [1:0]   in_op;
   logic         in_cin;
   logic         out_valid, out_ready;
   logic [W-1:0] out_sum;
   logic         out_c, out_v, out_z, out_n;

   int errors = 0;
   int checks = 0;
   int n_out  = 0;
   int rdy_mode = 0;
   logic saw_stall = 1'b0;
   logic [EW-1:0] exp_q[$];
   vec_t tbl[12];

   addsub_cla_pipe #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_cin(in_cin),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_c(out_c), .out_v(out_v), .out_z(out_z), .out_n(out_n)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   function automatic vec_t mk(input logic [W-1:0] a, b, input logic [1:0] op, input logic cin,
                               input logic [W-1:0] sum, input logic c, v, z, n);
      vec_t r;
      r.a = a; r.b = b; r.op = op; r.cin = cin;
      r.sum = sum; r.c = c; r.v = v; r.z = z; r.n = n;
      return r;
   endfunction

   function automatic logic [EW-1:0] model(input logic [W-1:0] a, b, input logic [1:0] op,
                                           input logic cin);
      logic [W-1:0] be;
      logic         ci;
      logic [W:0]   full;
      logic [W-1:0] s;
      be   = (op == OP_SUB || op == OP_SBB) ? ~b : b;
      ci   = (op == OP_ADD) ? 1'b0 : (op == OP_SUB) ? 1'b1 : cin;
      full = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, ci};
      s    = full[W-1:0];
      return {s, full[W], (a[W-1] == be[W-1]) && (s[W-1] != a[W-1]), s == '0, s[W-1]};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Called at posedge+1; returns at posedge+1 after the beat was accepted.
   task automatic drive(input logic [W-1:0] a, b, input logic [1:0] op, input logic cin,
                        input logic [EW-1:0] exp);
      logic ok;
      int   budget;
      in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_cin = cin;
      ok = 1'b0; budget = 0;
      while (!ok && budget < 100) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         budget++;
      end
      if (ok) exp_q.push_back(exp);
      else begin
         checks++; errors++;
         $display("FAIL accept_timeout: in_ready low for %0d cycles", budget);
      end
      #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int budget;
      budget = 0;
      in_valid = 1'b0;
      while (exp_q.size() != 0 && budget < 300) begin
         @(posedge clk);
         budget++;
      end
      #1;
      check("drain_queue_empty", exp_q.size(), 0);
   endtask

   task automatic ready_driver();
      int m;
      forever begin
         @(posedge clk);
         m = rdy_mode;
         #1;
         case (m)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
         endcase
      end
   endtask

   // ---------------- scoreboard ----------------
   task automatic monitor();
      logic [EW-1:0] act;
      forever begin
         @(negedge clk);
         if (!in_ready) saw_stall = 1'b1;
         if (!rst && out_valid) begin
            act = {out_sum, out_c, out_v, out_z, out_n};
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_output: got %0h with nothing expected", act);
            end else begin
               if (act !== exp_q[0]) begin
                  errors++;
                  $display("FAIL %s: got %0h expected %0h",
                           out_ready ? "result" : "stall_hold", act, exp_q[0]);
               end
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  n_out++;
               end
            end
         end
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int n0;
      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = OP_ADD; in_cin = 1'b0;
      out_ready = 1'b1;

      tbl[0]  = mk(32'h0000_00FF, 32'h0000_0001, OP_ADD, 1'b0, 32'h0000_0100, 0, 0, 0, 0);
      tbl[1]  = mk(32'hFFFF_FFFF, 32'h0000_0001, OP_ADD, 1'b0, 32'h0000_0000, 1, 0, 1, 0);
      tbl[2]  = mk(32'h8000_0000, 32'h0000_0001, OP_SUB, 1'b0, 32'h7FFF_FFFF, 1, 1, 0, 0);
      tbl[3]  = mk(32'h0000_0005, 32'h0000_0007, OP_SBB, 1'b0, 32'hFFFF_FFFD, 0, 0, 0, 1);
      tbl[4]  = mk(32'h7FFF_FFFF, 32'h0000_0000, OP_ADC, 1'b1, 32'h8000_0000, 0, 1, 0, 1);
      tbl[5]  = mk(32'h0000_0005, 32'h0000_0005, OP_SUB, 1'b1, 32'h0000_0000, 1, 0, 1, 0);
      tbl[6]  = mk(32'h0000_0007, 32'h0000_0005, OP_SBB, 1'b1, 32'h0000_0002, 1, 0, 0, 0);
      tbl[7]  = mk(32'h0000_0001, 32'h0000_0001, OP_ADD, 1'b1, 32'h0000_0002, 0, 0, 0, 0);
      tbl[8]  = mk(32'h00FF_00FF, 32'h0001_0001, OP_ADD, 1'b0, 32'h0100_0100, 0, 0, 0, 0);
      tbl[9]  = mk(32'h8000_0000, 32'h8000_0000, OP_ADD, 1'b0, 32'h0000_0000, 1, 1, 1, 0);
      tbl[10] = mk(32'h0000_0000, 32'h0000_0001, OP_SUB, 1'b0, 32'hFFFF_FFFF, 0, 0, 0, 1);
      tbl[11] = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_ADC, 1'b1, 32'hFFFF_FFFF, 1, 0, 0, 1);

      fork
         monitor();
         ready_driver();
      join_none

      // Reset state
      #3;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_sum", out_sum, 0);
      check("rst_flags", {out_c, out_v, out_z, out_n}, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("in_ready_after_reset", in_ready, 1);
      @(posedge clk); #1;

      // Latency on an empty pipeline, using the first table vector
      drive(tbl[0].a, tbl[0].b, tbl[0].op, tbl[0].cin,
            {tbl[0].sum, tbl[0].c, tbl[0].v, tbl[0].z, tbl[0].n});
      in_valid = 1'b0;
      @(negedge clk);
      check("latency_not_early", out_valid, 0);
      @(negedge clk);
      check("latency_two_cycles", out_valid, 1);
      @(posedge clk); #1;

      // Remaining vectors streamed back to back
      for (int i = 1; i < 12; i++)
         drive(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].cin,
               {tbl[i].sum, tbl[i].c, tbl[i].v, tbl[i].z, tbl[i].n});
      drain();

      // Backpressure: six ADD beats while the consumer stalls for four cycles
      saw_stall = 1'b0;
      n0 = n_out;
      fork
         begin
            for (int i = 0; i < 6; i++)
               drive(W'(i), 32'd1, OP_ADD, 1'b0, {W'(i + 1), 1'b0, 1'b0, 1'b0, 1'b0});
            in_valid = 1'b0;
         end
         begin
            repeat (2) @(posedge clk);
            #1 rdy_mode = 2;
            repeat (4) @(posedge clk);
            #1 rdy_mode = 0;
         end
      join
      drain();
      check("bp_in_ready_fell", saw_stall, 1);
      check("bp_beat_count", n_out - n0, 6);

      // Reset with two beats in flight
      rdy_mode = 2;
      idle(2);
      drive(32'd100, 32'd1, OP_ADD, 1'b0, model(32'd100, 32'd1, OP_ADD, 1'b0));
      drive(32'd200, 32'd1, OP_ADD, 1'b0, model(32'd200, 32'd1, OP_ADD, 1'b0));
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_out_sum", out_sum, 0);
      check("midrst_flags", {out_c, out_v, out_z, out_n}, 0);
      exp_q.delete();
      rdy_mode = 0;
      repeat (2) @(posedge clk);
      #1;
      check("midrst_hold_valid", out_valid, 0);
      rst = 1'b0;
      @(negedge clk);
      check("in_ready_after_midrst", in_ready, 1);
      @(posedge clk); #1;
      drive(32'd3, 32'd4, OP_ADD, 1'b0, {32'd7, 4'b0000});
      in_valid = 1'b0;
      @(negedge clk);
      check("post_rst_not_early", out_valid, 0);
      @(negedge clk);
      check("post_rst_valid", out_valid, 1);
      check("post_rst_sum", out_sum, 7);
      @(posedge clk); #1;
      drain();

      // Random traffic with random consumer stalls and input bubbles
      rdy_mode = 1;
      for (int i = 0; i < 60; i++) begin
         logic [W-1:0] a, b;
         logic [1:0]   op;
         logic         ci;
         a  = (i % 7 == 0) ? 32'hFFFF_FFFF : $urandom;
         b  = (i % 5 == 0) ? 32'h8000_0000 : $urandom;
         op = 2'($urandom_range(0, 3));
         ci = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) idle(1);
         drive(a, b, op, ci, model(a, b, op, ci));
      end
      in_valid = 1'b0;
      rdy_mode = 0;
      drain();
      repeat (4) @(posedge clk);
      #1;
      check("final_queue_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/addsub_cla_pipe.md
Name: addsub_cla_pipe

Overview:
- Two-stage pipelined WIDTH-bit adder/subtractor with valid/ready handshake at both ends.
- Built as the second level of the group carry-lookahead tree: 8-bit groups produce per-group group-generate/propagate and precomputed sums.
- A registered lookahead stage resolves the inter-group carries, selects the final sum and produces ALU flags.
- Sits between the ALU operand mux (upstream) and the result/flag writeback register (downstream).

Parameters:
WIDTH, 32, operand/result width; must be a multiple of 8, legal range 8..64
NGRP, WIDTH/8, number of 8-bit groups; derived, not overridable

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  operand beat present
in_ready  output  1  block can accept a beat this cycle
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_op  input  2  00 ADD, 01 SUB, 10 ADC, 11 SBB
in_cin  input  1  carry-in; used by ADC/SBB only
out_valid  output  1  result beat present
out_ready  input  1  consumer accepts the beat
out_sum  output  WIDTH  result
out_c  output  1  carry out of MSB; for SUB/SBB, 1 = no borrow
out_v  output  1  signed overflow
out_z  output  1  out_sum == 0
out_n  output  1  out_sum[WIDTH-1]

Behaviour:
- Operand prep (combinational, ahead of stage 1):
  - b_eff = in_b for ADD/ADC, ~in_b for SUB/SBB.
  - cin_eff: ADD = 0, SUB = 1, ADC/SBB = in_cin.
- Stage 1 (S1, registered on in_valid && in_ready), per group k:
  - 8-bit group sum with carry-in 0 (sum0[k]) and with carry-in 1 (sum1[k]).
  - Group G[k] and P[k].
  - Also registers cin_eff, a_msb and b_eff_msb.
- Stage 2 (S2), group carry resolution:
  - c[0] = cin_eff; c[k+1] = G[k] | (P[k] & c[k]), written as flattened lookahead sum-of-products, not a ripple chain.
  - Group k sum = c[k] ? sum1[k] : sum0[k].
  - out_c = c[NGRP].
  - out_v = (a_msb == b_eff_msb) && (out_sum MSB != a_msb).
  - out_z and out_n derived from the final sum.
  - All outputs are registered.
- Latency: exactly 2 cycles from accepted input to out_valid, with no stalls. Throughput is 1 beat/cycle.
- Handshake:
  - Beat transfers on valid && ready.
  - s2_adv = !out_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv, combinational from out_ready and state only, never from in_valid.
  - While out_valid && !out_ready: out_sum and all flags hold stable.
  - Upstream may drop in_valid freely; bubbles propagate as valid = 0.
- Simultaneous events: S2 drain, S1→S2 move and a new S1 capture all occur in the same cycle when out_ready = 1 and both stages are full.
- Reset:
  - s1_valid, out_valid, out_sum and all flags go to 0 immediately on rst assertion.
  - in_ready is 1 after reset.
  - In-flight beats are discarded; no partial result is ever presented.
- Wrap-around: the sum is modulo 2^WIDTH; the carry appears only on out_c.

Decomposition:
- Shared package alu_pkg:
  - op encoding constants OP_ADD/OP_SUB/OP_ADC/OP_SBB.
  - GRP_W = 8.
  - Flag bundle typedef {c, v, z, n}.
- One sub-module, cla_group_8: combinational 8-bit group CLA with inputs a, b, cin and outputs s, g, p.
  - Instantiated 2×NGRP times in S1.
  - The g/p from the cin = 0 instance is used; the cin = 1 instance's g/p is left unconnected.

Test Plan:
- ADD 0x0000_00FF + 0x0000_0001, out_ready = 1 → two cycles later sum 0x0000_0100; c, v, z, n = 0. Exercises the group-0→1 carry.
- ADD 0xFFFF_FFFF + 0x0000_0001 → sum 0, c = 1, z = 1, v = 0. Carry ripples through all groups.
- SUB 0x8000_0000 − 0x0000_0001 → 0x7FFF_FFFF, c = 1, v = 1, n = 0.
- SBB with in_cin = 0: 5 − 7 → 0xFFFF_FFFD, c = 0 (borrow), n = 1.
- Backpressure: stream 6 ADD beats (i + 1) with out_ready low for cycles 3–6.
  - in_ready falls once both stages are full.
  - Outputs hold stable while stalled.
  - All 6 results appear in order, none lost or duplicated.
- Reset mid-stream: assert rst with 2 beats in flight → out_valid = 0 and out_sum = 0 during reset, and in_ready = 1 after release. The first post-reset beat 3 + 4 yields 7 after 2 cycles.
